// File: rtl/div_pkg.sv
// div_pkg: width constants, FSM encoding and standard-cell transistor costs
// shared by the 8-bit/5-bit divider and its inverse, mul_seq.
//   QW   quotient width / iteration count
//   BW   divisor and remainder width
//   AW   reconstructed-dividend width (QW+BW)
package div_pkg;

  localparam int unsigned QW    = 8;
  localparam int unsigned BW    = 5;
  localparam int unsigned AW    = QW + BW;
  localparam int unsigned ITER  = QW;
  localparam int unsigned CW    = $clog2(ITER);
  localparam int unsigned NUM_W = 51;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Standard gate cell transistor costs.
  localparam int unsigned T_AND2 = 6;
  localparam int unsigned T_OR2  = 6;
  localparam int unsigned T_FA   = 28;
  localparam int unsigned T_DFF  = 24;

endpackage

// File: rtl/mul_acc_step.sv
// mul_acc_step: one shift-add iteration. The multiplicand is gated by the
// multiplier LSB (AND2 per bit) and added to the accumulator through an
// AW-bit ripple full-adder chain; the carry-out is dropped.
//   acc     current accumulator
//   mcand   current (shifted) multiplicand
//   en      multiplier LSB
//   sum     next accumulator value
//   number  transistor count of this cell group (constant)
module mul_acc_step
  import div_pkg::*;
(
  input  logic [AW-1:0]    acc,
  input  logic [AW-1:0]    mcand,
  input  logic             en,
  output logic [AW-1:0]    sum,
  output logic [NUM_W-1:0] number
);

  always_comb begin
    logic carry;
    logic g;
    carry = 1'b0;
    g     = 1'b0;
    sum   = '0;
    for (int unsigned i = 0; i < AW; i++) begin
      g      = mcand[i] & en;
      sum[i] = acc[i] ^ g ^ carry;
      carry  = (acc[i] & g) | (carry & (acc[i] ^ g));
    end
  end

  assign number = NUM_W'(AW * (T_AND2 + T_FA));

endmodule

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-add multiplier-accumulator, o_a = i_q*i_b + i_r,
// one quotient bit per clock over QW clocks. Inverse of the array divider.
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   i_in_valid    operand strobe, sampled only in IDLE or DONE
//   i_q, i_b, i_r quotient (multiplier), divisor, remainder (seed)
//   o_a           reconstructed dividend, updated only when a run completes
//   o_out_valid   one-cycle result pulse
//   o_busy        high while iterating
//   number        total transistor count of instantiated cells (constant)
//   o_err         (MUL_CHECK_EN only) operand triple was not a legal divider
//                 output; valid alongside o_out_valid, held otherwise
module mul_seq
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  input  logic [QW-1:0]    i_q,
  input  logic [BW-1:0]    i_b,
  input  logic [BW-1:0]    i_r,
  output logic [AW-1:0]    o_a,
  output logic             o_out_valid,
  output logic             o_busy,
`ifdef MUL_CHECK_EN
  output logic             o_err,
`endif
  output logic [NUM_W-1:0] number
);

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [QW-1:0]    mq;
  logic [AW-1:0]    mb;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_next;
  logic [NUM_W-1:0] step_number;
  logic             accept;
  logic             last;

  // state(2) + cnt + multiplier + multiplicand + accumulator + o_a + valid
  localparam int unsigned N_FLOPS = 2 + CW + QW + AW + AW + AW + 1;
`ifdef MUL_CHECK_EN
  // captured flag + o_err flops, r>=b subtractor, b==0 and overflow OR trees
  localparam int unsigned CHK_TR = 2 * T_DFF + BW * T_FA + (2 * (BW - 1) + 2) * T_OR2;
`else
  localparam int unsigned CHK_TR = 0;
`endif

  assign accept = (state != RUN) && i_in_valid;
  assign last   = (cnt == CW'(ITER - 1));

  mul_acc_step u_step (
    .acc    (acc),
    .mcand  (mb),
    .en     (mq[0]),
    .sum    (acc_next),
    .number (step_number)
  );

  assign number = step_number + NUM_W'(N_FLOPS * T_DFF + CHK_TR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = i_in_valid ? RUN : IDLE;
      RUN:     state_next = last ? DONE : RUN;
      DONE:    state_next = i_in_valid ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded straight from the state flops, so it cannot glitch at DONE.
  always_comb begin
    o_busy = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      mq          <= '0;
      mb          <= '0;
      acc         <= '0;
      o_a         <= '0;
      o_out_valid <= 1'b0;
    end else begin
      o_out_valid <= (state == RUN) && last;
      if (accept) begin
        mq  <= i_q;
        mb  <= {{QW{1'b0}}, i_b};
        acc <= {{QW{1'b0}}, i_r};
        cnt <= '0;
      end else if (state == RUN) begin
        acc <= acc_next;
        mb  <= {mb[AW-2:0], 1'b0};
        mq  <= {1'b0, mq[QW-1:1]};
        cnt <= cnt + CW'(1);
        if (last) o_a <= acc_next;
      end
    end
  end

`ifdef MUL_CHECK_EN
  logic bad_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_in <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      if (accept) bad_in <= (i_b == '0) || (i_r >= i_b);
      // A legal dividend never exceeds QW bits.
      if ((state == RUN) && last) o_err <= bad_in || (|acc_next[AW-1:QW]);
    end
  end
`endif

endmodule
